axi_tdd_ng_frame_ctrl: RTL and testbench

AXI_TDD_NG_FRAME_CTRL -- requirements
Module: axi_tdd_ng_frame_ctrl

---
 rtl/axi_tdd_ng_pkg.sv | 15 +
 rtl/axi_tdd_ng_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_axi_tdd_ng_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_tdd_ng_pkg.sv
// axi_tdd_ng_pkg: shared types for the TDD next-gen frame controller.
`default_nettype none

package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } tdd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_tdd_ng_frame_ctrl.sv
// ------------------------------------------------------------------------
// axi_tdd_ng_frame_ctrl: sync-triggered frame sequencer (delay, L-cycle
// frames, B-frame bursts). Optional macro AXI_TDD_NG_SYNC_RESET_EN.
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

module axi_tdd_ng_frame_ctrl #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync,
  input  logic                         tdd_sync_rst,
  input  logic [REGISTER_WIDTH-1:0]    asy_tdd_frame_length,
  input  logic [REGISTER_WIDTH-1:0]    asy_tdd_startup_delay,
  input  logic [BURST_COUNT_WIDTH-1:0] asy_tdd_burst_count,
  output logic [1:0]                   tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic                         tdd_endof_frame,
  output logic                         tdd_running
);

  import axi_tdd_ng_pkg::*;

  localparam logic [REGISTER_WIDTH-1:0]    C_RONE = {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_COUNT_WIDTH-1:0] C_BONE = {{(BURST_COUNT_WIDTH-1){1'b0}}, 1'b1};

  tdd_state_t                   state;
  logic [REGISTER_WIDTH-1:0]    counter;
  logic [BURST_COUNT_WIDTH-1:0] tally;
  logic [REGISTER_WIDTH-1:0]    frame_length;
  logic [REGISTER_WIDTH-1:0]    startup_delay;
  logic [BURST_COUNT_WIDTH-1:0] burst_count;

  logic [REGISTER_WIDTH-1:0]    frame_last;
  logic [REGISTER_WIDTH-1:0]    delay_last;
  logic [BURST_COUNT_WIDTH-1:0] burst_last;
  logic                         endof_frame;
  logic                         sync_restart;

  // L=0 wraps frame_last to all-ones, giving a full 2^W-cycle frame.
  assign frame_last  = frame_length - C_RONE;
  assign delay_last  = startup_delay - C_RONE;
  assign burst_last  = burst_count - C_BONE;
  assign endof_frame = (state == RUNNING) && (counter == frame_last);

`ifdef AXI_TDD_NG_SYNC_RESET_EN
  assign sync_restart = tdd_sync && tdd_sync_rst &&
                        ((state == WAITING) || (state == RUNNING));
`else
  logic unused_sync_rst;
  assign unused_sync_rst = tdd_sync_rst;
  assign sync_restart    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      counter       <= '0;
      tally         <= '0;
      frame_length  <= '0;
      startup_delay <= '0;
      burst_count   <= '0;
    end else if (!tdd_enable) begin
      state   <= IDLE;
      counter <= '0;
      tally   <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_length  <= asy_tdd_frame_length;
          startup_delay <= asy_tdd_startup_delay;
          burst_count   <= asy_tdd_burst_count;
          state         <= ARMED;
        end
        ARMED: begin
          if (tdd_sync) begin
            state   <= (startup_delay != '0) ? WAITING : RUNNING;
            counter <= '0;
            tally   <= '0;
          end
        end
        WAITING: begin
          if (sync_restart) begin
            state   <= (startup_delay != '0) ? WAITING : RUNNING;
            counter <= '0;
            tally   <= '0;
          end else if (counter == delay_last) begin
            state   <= RUNNING;
            counter <= '0;
          end else begin
            counter <= counter + C_RONE;
          end
        end
        RUNNING: begin
          if (sync_restart) begin
            state   <= (startup_delay != '0) ? WAITING : RUNNING;
            counter <= '0;
            tally   <= '0;
          end else if (endof_frame) begin
            counter <= '0;
            // Last frame of a finite burst re-arms for the next sync.
            if ((burst_count != '0) && (tally == burst_last)) begin
              state <= ARMED;
              tally <= '0;
            end else begin
              tally <= tally + C_BONE;
            end
          end else begin
            counter <= counter + C_RONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tdd_cstate      = state;
  assign tdd_counter     = counter;
  assign tdd_endof_frame = endof_frame;
  assign tdd_running     = (state == RUNNING);

endmodule

`default_nettype wire

// File: tb/tb_axi_tdd_ng_frame_ctrl.sv
// tb_axi_tdd_ng_frame_ctrl: directed scenarios plus random traffic, scored
// against a cycle-level behavioural model through an expectation queue.
`default_nettype none

module tb_axi_tdd_ng_frame_ctrl;

  localparam int RW = 8;
  localparam int BW = 4;
  localparam longint MASK = (64'd1 << RW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tdd_enable = 1'b0;
  logic          tdd_sync = 1'b0;
  logic          tdd_sync_rst = 1'b0;
  logic [RW-1:0] asy_tdd_frame_length = '0;
  logic [RW-1:0] asy_tdd_startup_delay = '0;
  logic [BW-1:0] asy_tdd_burst_count = '0;
  logic [1:0]    tdd_cstate;
  logic [RW-1:0] tdd_counter;
  logic          tdd_endof_frame;
  logic          tdd_running;

  axi_tdd_ng_frame_ctrl #(.REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .tdd_enable           (tdd_enable),
    .tdd_sync             (tdd_sync),
    .tdd_sync_rst         (tdd_sync_rst),
    .asy_tdd_frame_length (asy_tdd_frame_length),
    .asy_tdd_startup_delay(asy_tdd_startup_delay),
    .asy_tdd_burst_count  (asy_tdd_burst_count),
    .tdd_cstate           (tdd_cstate),
    .tdd_counter          (tdd_counter),
    .tdd_endof_frame      (tdd_endof_frame),
    .tdd_running          (tdd_running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     st;
    longint cnt;
    bit     eof;
    bit     run;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     eof_seen = 0;

  // Behavioural model: phase (0 idle,1 armed,2 delay,3 frames), position
  // inside the current phase, frames finished in this burst.
  int     m_phase = 0;
  longint m_pos = 0;
  longint m_frames = 0;
  longint m_len = 0, m_dly = 0, m_bst = 0;
  bit     sync_rst_feature;

  initial begin
`ifdef AXI_TDD_NG_SYNC_RESET_EN
    sync_rst_feature = 1'b1;
`else
    sync_rst_feature = 1'b0;
`endif
  end

  function automatic longint frame_period();
    return (m_len == 0) ? (MASK + 1) : m_len;
  endfunction

  task automatic model_start();
    m_pos    = 0;
    m_frames = 0;
    m_phase  = (m_dly != 0) ? 2 : 3;
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (!resetn) begin
      m_phase = 0; m_pos = 0; m_frames = 0; m_len = 0; m_dly = 0; m_bst = 0;
    end else if (!tdd_enable) begin
      m_phase = 0; m_pos = 0; m_frames = 0;
    end else if (m_phase == 0) begin
      m_len = asy_tdd_frame_length; m_dly = asy_tdd_startup_delay;
      m_bst = asy_tdd_burst_count;  m_phase = 1;
    end else if (m_phase == 1) begin
      if (tdd_sync) model_start();
    end else if (sync_rst_feature && tdd_sync && tdd_sync_rst) begin
      model_start();
    end else if (m_phase == 2) begin
      m_pos = m_pos + 1;
      if (m_pos == m_dly) begin m_phase = 3; m_pos = 0; end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == frame_period()) begin
        m_pos    = 0;
        m_frames = m_frames + 1;
        if (m_bst != 0 && m_frames == m_bst) begin m_phase = 1; m_frames = 0; end
      end
    end
    e.st  = m_phase;
    e.cnt = m_pos;
    e.eof = (m_phase == 3) && (m_pos == frame_period() - 1);
    e.run = (m_phase == 3);
    sb.push_back(e);
  end

  // Monitor: the DUT presents a new output word every cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb.pop_front();
      total++;
      if (tdd_cstate !== e.st[1:0] || tdd_counter !== e.cnt[RW-1:0] ||
          tdd_endof_frame !== e.eof || tdd_running !== e.run) begin
        bad++;
        $display("FAIL cycle_check t=%0t got st=%0d cnt=%0d eof=%0b run=%0b exp st=%0d cnt=%0d eof=%0b run=%0b",
                 $time, tdd_cstate, tdd_counter, tdd_endof_frame, tdd_running,
                 e.st, e.cnt, e.eof, e.run);
      end
      if (tdd_endof_frame === 1'b1) eof_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int l, input int d, input int b);
    asy_tdd_frame_length  = l[RW-1:0];
    asy_tdd_startup_delay = d[RW-1:0];
    asy_tdd_burst_count   = b[BW-1:0];
  endtask

  task automatic pulse_sync(input bit with_rst);
    tdd_sync = 1'b1; tdd_sync_rst = with_rst;
    cyc(1);
    tdd_sync = 1'b0; tdd_sync_rst = 1'b0;
  endtask

  // Bounded wait for the model to reach RUNNING at a given position.
  task automatic wait_run_pos(input int p);
    int n = 0;
    while (!(m_phase == 3 && m_pos == p) && n < 600) begin cyc(1); n++; end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL wait_run_pos timeout pos=%0d", p);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (tdd_cstate !== 2'd0 || tdd_counter !== '0 || tdd_endof_frame !== 1'b0 || tdd_running !== 1'b0) begin
      bad++;
      $display("FAIL %s got st=%0d cnt=%0d eof=%0b run=%0b exp all 0",
               name, tdd_cstate, tdd_counter, tdd_endof_frame, tdd_running);
    end
  endtask

  initial begin
    int eof_before;
    #2;
    check_zero("reset_outputs");
    cyc(3);
    resetn = 1'b1;
    cyc(2);

    // Basic burst: L=10, D=3, B=2.
    cfg(10, 3, 2);
    tdd_enable = 1'b1;
    cyc(2);
    eof_before = eof_seen;
    pulse_sync(1'b0);
    cyc(30);
    total++;
    if (eof_seen - eof_before != 2) begin
      bad++;
      $display("FAIL basic_eof_count got %0d exp 2", eof_seen - eof_before);
    end
    tdd_enable = 1'b0; cyc(2);

    // Zero delay, infinite bursts, then a frame-length change mid-run.
    cfg(4, 0, 0);
    tdd_enable = 1'b1; cyc(2);
    pulse_sync(1'b0);
    cyc(110);
    cfg(7, 2, 1);
    cyc(20);

    // Disable at counter 5 with a simultaneous sync.
    tdd_enable = 1'b0; cyc(2);
    cfg(9, 1, 0);
    tdd_enable = 1'b1; cyc(2);
    pulse_sync(1'b0);
    wait_run_pos(5);
    tdd_enable = 1'b0; tdd_sync = 1'b1;
    cyc(1);
    tdd_sync = 1'b0;
    cyc(2);

    // Sync restart at counter 6.
    cfg(10, 2, 0);
    tdd_enable = 1'b1; cyc(2);
    pulse_sync(1'b0);
    wait_run_pos(6);
    pulse_sync(1'b1);
    cyc(15);

    // Asynchronous reset mid-cycle, released with enable still high.
    wait_run_pos(3);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    cyc(3);
    resetn = 1'b1;
    cfg(3, 0, 1);
    cyc(3);
    pulse_sync(1'b0);
    cyc(8);

    // L=0: full 2^RW-cycle frame, single-frame burst.
    tdd_enable = 1'b0; cyc(2);
    cfg(0, 1, 1);
    tdd_enable = 1'b1; cyc(2);
    pulse_sync(1'b0);
    cyc(262);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tdd_enable   = ($urandom_range(0, 99) != 0);
      tdd_sync     = ($urandom_range(0, 9) == 0);
      tdd_sync_rst = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0)
        cfg(($urandom_range(0, 30) == 0) ? 0 : $urandom_range(1, 12),
            $urandom_range(0, 5), $urandom_range(0, 3));
      cyc(1);
    end
    tdd_sync = 1'b0; tdd_sync_rst = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
